wb_rr_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_rr_picker.sv | 29 ++
 rtl/wb_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the Wishbone round-robin arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWNED,
    ARB_ABORT
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  typedef enum logic {
    RETURN_ACK,
    RETURN_ERR
  } ret_t;

  localparam int OUTST_W = 3;

endpackage

// File: rtl/wb_rr_picker.sv
// rtl/wb_rr_picker.sv - combinational round-robin picker, scans from last_grant+1 with wrap
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N-1:0]     grant_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IDX_W'((int'(last_grant_i) + i) % N);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter with per-transfer watchdog in front of the WB2APB bridge
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 2,
  parameter  int ADDR_WIDTH     = 16,
  parameter  int DATA_WIDTH     = 32,
  parameter  int GRANULE        = 8,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int SEL_WIDTH      = DATA_WIDTH / GRANULE
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              timeout_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [OUTST_W-1:0]     outst_q, outst_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] pick;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  logic                   owner_cyc, owner_stb, owner_we;
  logic [ADDR_WIDTH-1:0]  owner_adr;
  logic [SEL_WIDTH-1:0]   owner_sel;
  logic [DATA_WIDTH-1:0]  owner_dat;
  logic                   owned, resp, wd_active;

  wb_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req_i        (m_cyc_i),
    .last_grant_i (last_q),
    .grant_o      (pick),
    .valid_o      (pick_valid)
  );

  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    owner_we  = 1'b0;
    owner_adr = '0;
    owner_sel = '0;
    owner_dat = '0;
    pick_idx  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        owner_cyc = m_cyc_i[k];
        owner_stb = m_stb_i[k];
        owner_we  = m_we_i[k];
        owner_adr = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        owner_sel = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
        owner_dat = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (pick[k]) pick_idx = IDX_W'(k);
    end
  end

  // Reset gates the bus immediately so a mid-cycle reset never leaks an ACK/ERR.
  assign owned   = (state_q == ARB_OWNED) && !rst_i;
  assign s_cyc_o = owned && owner_cyc;
  assign s_stb_o = owned && owner_cyc && owner_stb;
  assign s_we_o  = owned && owner_we;
  assign s_adr_o = owned ? owner_adr : '0;
  assign s_sel_o = owned ? owner_sel : '0;
  assign s_dat_o = owned ? owner_dat : '0;

  assign resp      = s_ack_i || s_err_i;
  assign wd_active = (outst_q != '0) || s_stb_o;

  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = (owned && s_ack_i) ? grant_q : '0;
  assign m_err_o   = ((owned && s_err_i) ? grant_q : '0)
                   | ((timeout_q && !rst_i) ? grant_q : '0);
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    outst_d   = outst_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        outst_d = '0;
        wd_d    = '0;
        if (pick_valid) begin
          state_d = ARB_OWNED;
          grant_d = pick;
          last_d  = pick_idx;
        end
      end
      ARB_OWNED: begin
        if (!owner_cyc) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          outst_d = '0;
          wd_d    = '0;
        end else begin
          if (s_stb_o && !resp && (outst_q != '1)) begin
            outst_d = outst_q + 1'b1;
          end else if (resp && !s_stb_o && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
          end
          // A response in the expiry cycle resets the count, so it beats the abort.
          if (resp) begin
            wd_d = '0;
          end else if (wd_active) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
              state_d   = ARB_ABORT;
              timeout_d = 1'b1;
              wd_d      = '0;
              outst_d   = '0;
            end else begin
              wd_d = wd_q + 1'b1;
            end
          end
        end
      end
      ARB_ABORT: begin
        if (!owner_cyc) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
      outst_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      outst_q   <= outst_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter with grant and response scoreboards
module tb_wb_rr_arbiter;
  import wb_arb_pkg::*;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [NM-1:0] m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [AW-1:0] adr_a [NM];
  logic [DW-1:0] dat_a [NM];
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [DW-1:0] m_dat_o;
  logic [NM-1:0] m_ack_o, m_err_o, grant_o;
  logic          s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat_i = '0;
  logic          s_ack_i = 1'b0, s_err_i = 1'b0;

  assign m_adr_i = {adr_a[1], adr_a[0]};
  assign m_dat_i = {dat_a[1], dat_a[0]};
  assign m_sel_i = '1;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  typedef struct {
    int          m;
    ret_t        r;
    bit          chk;
    logic [31:0] d;
  } resp_t;

  resp_t         resp_sb[$];
  int            grant_sb[$];
  int            tests_run = 0;
  int            fails = 0;
  logic [NM-1:0] prev_grant = '0;
  int            exp_g;
  resp_t         exp_r;
  logic [NM-1:0] exp_ack, exp_err;

  always @(negedge clk) begin
    if (rst_i) begin
      prev_grant <= '0;
    end else begin
      if (grant_o !== prev_grant && grant_o !== '0) begin
        tests_run++;
        if (grant_sb.size() == 0) begin
          fails++;
          $display("FAIL grant_order: got unexpected grant %b, wanted none", grant_o);
        end else begin
          exp_g = grant_sb.pop_front();
          if (grant_o !== (NM'(1) << exp_g)) begin
            fails++;
            $display("FAIL grant_order: got %b, wanted %b", grant_o, NM'(1) << exp_g);
          end
        end
      end
      prev_grant <= grant_o;
      if ((m_ack_o | m_err_o) !== '0) begin
        tests_run++;
        if (resp_sb.size() == 0) begin
          fails++;
          $display("FAIL response: got unexpected ack %b err %b", m_ack_o, m_err_o);
        end else begin
          exp_r   = resp_sb.pop_front();
          exp_ack = (exp_r.r == RETURN_ACK) ? (NM'(1) << exp_r.m) : '0;
          exp_err = (exp_r.r == RETURN_ERR) ? (NM'(1) << exp_r.m) : '0;
          if (m_ack_o !== exp_ack || m_err_o !== exp_err) begin
            fails++;
            $display("FAIL response: got ack %b err %b, wanted ack %b err %b",
                     m_ack_o, m_err_o, exp_ack, exp_err);
          end else if (exp_r.chk && m_dat_o !== exp_r.d) begin
            fails++;
            $display("FAIL read_data: got %h, wanted %h", m_dat_o, exp_r.d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc_i[m] = cyc;
    m_stb_i[m] = stb;
    m_we_i[m]  = we;
    adr_a[m]   = adr;
    dat_a[m]   = dat;
  endtask

  task automatic wait_grant(output bit ok);
    bit saw_idle;
    int n;
    saw_idle = (grant_o === '0);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 12) begin
      @(negedge clk);
      n++;
      if (grant_o === '0) saw_idle = 1'b1;
      else if (saw_idle) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    drive_m(1'b0, 0, 0, 0, '0, '0);
    drive_m(1'b1, 0, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o, timeout_o} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got grant %b cyc %b stb %b ack %b err %b to %b, wanted all 0",
               grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, timeout_o);
    end
    tests_run++;
    if ({s_adr_o, s_sel_o, s_dat_o} !== '0) begin
      fails++;
      $display("FAIL reset_bus: got adr %h sel %h dat %h, wanted 0", s_adr_o, s_sel_o, s_dat_o);
    end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_classic_read();
    bit ok;
    tick();
    drive_m(1'b0, 1, 1, 0, 16'h0010, '0);
    drive_m(1'b1, 1, 1, 0, 16'h0050, '0);
    grant_sb.push_back(0);
    grant_sb.push_back(1);
    resp_sb.push_back('{0, RETURN_ACK, 1'b1, 32'hDEADBEEF});
    @(negedge clk);
    tests_run++;
    if (s_cyc_o !== 1'b0) begin
      fails++;
      $display("FAIL grant_latency: got s_cyc_o %b, wanted 0", s_cyc_o);
    end
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    tests_run++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 16'h0010 || grant_o !== 2'b01) begin
      fails++;
      $display("FAIL m0_owned: got cyc %b adr %h grant %b, wanted 1 0010 01", s_cyc_o, s_adr_o, grant_o);
    end
    tick();
    s_ack_i = 1'b0;
    drive_m(1'b0, 0, 0, 0, '0, '0);
    tick();
    @(negedge clk);
    tests_run++;
    if (s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
      fails++;
      $display("FAIL idle_gap: got cyc %b grant %b, wanted 0 00", s_cyc_o, grant_o);
    end
    wait_grant(ok);
    tests_run++;
    if (!ok || grant_o !== 2'b10 || s_adr_o !== 16'h0050) begin
      fails++;
      $display("FAIL m1_owned: got grant %b adr %h, wanted 10 0050", grant_o, s_adr_o);
    end
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'hCAFEF00D;
    resp_sb.push_back('{1, RETURN_ACK, 1'b1, 32'hCAFEF00D});
    tick();
    s_ack_i = 1'b0;
    drive_m(1'b1, 0, 0, 0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_fairness();
    bit ok;
    logic o;
    tick();
    drive_m(1'b0, 1, 0, 0, 16'h0100, '0);
    drive_m(1'b1, 1, 0, 0, 16'h0200, '0);
    for (int k = 0; k < 4; k++) begin
      o = k[0];
      grant_sb.push_back(k % 2);
      wait_grant(ok);
      tests_run++;
      if (!ok || grant_o !== (2'b01 << o)) begin
        fails++;
        $display("FAIL fairness_%0d: got grant %b, wanted %b", k, grant_o, 2'b01 << o);
      end
      repeat (3) tick();
      tick();
      if (k == 3) begin
        drive_m(1'b0, 0, 0, 0, '0, '0);
        drive_m(1'b1, 0, 0, 0, '0, '0);
      end else begin
        m_cyc_i[o] = 1'b0;
        tick();
        m_cyc_i[o] = 1'b1;
      end
    end
    tick();
    tick();
  endtask

  task automatic test_rmw();
    bit ok;
    tick();
    drive_m(1'b1, 1, 1, 0, 16'h0020, '0);
    grant_sb.push_back(1);
    resp_sb.push_back('{1, RETURN_ACK, 1'b1, 32'h11223344});
    wait_grant(ok);
    tests_run++;
    if (!ok || grant_o !== 2'b10) begin
      fails++;
      $display("FAIL rmw_grant: got %b, wanted 10", grant_o);
    end
    tick();
    drive_m(1'b0, 1, 1, 0, 16'h0040, '0);
    s_ack_i = 1'b1;
    s_dat_i = 32'h11223344;
    @(negedge clk);
    tests_run++;
    if (s_adr_o !== 16'h0020 || m_ack_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL rmw_read: got adr %h m0_ack %b, wanted 0020 0", s_adr_o, m_ack_o[0]);
    end
    tick();
    s_ack_i = 1'b0;
    drive_m(1'b1, 1, 0, 0, 16'h0020, '0);
    tick();
    drive_m(1'b1, 1, 1, 1, 16'h0020, 32'hAABBCCDD);
    @(negedge clk);
    tests_run++;
    if (s_we_o !== 1'b1 || s_stb_o !== 1'b1 || s_dat_o !== 32'hAABBCCDD || grant_o !== 2'b10) begin
      fails++;
      $display("FAIL rmw_write: got we %b stb %b dat %h grant %b, wanted 1 1 aabbccdd 10",
               s_we_o, s_stb_o, s_dat_o, grant_o);
    end
    tick();
    s_ack_i = 1'b1;
    resp_sb.push_back('{1, RETURN_ACK, 1'b0, 32'h0});
    @(negedge clk);
    tests_run++;
    if (m_ack_o[0] !== 1'b0 || grant_o !== 2'b10) begin
      fails++;
      $display("FAIL rmw_hold: got m0_ack %b grant %b, wanted 0 10", m_ack_o[0], grant_o);
    end
    tick();
    s_ack_i = 1'b0;
    drive_m(1'b1, 0, 0, 0, '0, '0);
    grant_sb.push_back(0);
    resp_sb.push_back('{0, RETURN_ACK, 1'b1, 32'h5555AAAA});
    @(negedge clk);
    tests_run++;
    if (grant_o !== 2'b10 || s_cyc_o !== 1'b0) begin
      fails++;
      $display("FAIL rmw_release: got grant %b cyc %b, wanted 10 0", grant_o, s_cyc_o);
    end
    wait_grant(ok);
    tests_run++;
    if (!ok || grant_o !== 2'b01) begin
      fails++;
      $display("FAIL rmw_next: got %b, wanted 01", grant_o);
    end
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h5555AAAA;
    tick();
    s_ack_i = 1'b0;
    drive_m(1'b0, 0, 0, 0, '0, '0);
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int seen;
    tick();
    drive_m(1'b0, 1, 1, 1, 16'h0030, 32'h01020304);
    grant_sb.push_back(0);
    resp_sb.push_back('{0, RETURN_ERR, 1'b0, 32'h0});
    wait_grant(ok);
    tests_run++;
    if (!ok || grant_o !== 2'b01 || s_stb_o !== 1'b1) begin
      fails++;
      $display("FAIL to_strobe: got grant %b stb %b, wanted 01 1", grant_o, s_stb_o);
    end
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin
        drive_m(1'b0, 1, 0, 1, 16'h0030, 32'h01020304);
        drive_m(1'b1, 1, 1, 0, 16'h0060, '0);
      end
      @(negedge clk);
      if (timeout_o === 1'b1) begin
        seen = c;
        tests_run++;
        if (s_cyc_o !== 1'b0 || m_err_o !== 2'b01) begin
          fails++;
          $display("FAIL to_abort: got cyc %b err %b, wanted 0 01", s_cyc_o, m_err_o);
        end
        break;
      end
    end
    tests_run++;
    if (seen != TO) begin
      fails++;
      $display("FAIL to_cycle: got timeout at cycle %0d, wanted %0d", seen, TO);
    end
    tick();
    s_ack_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (timeout_o !== 1'b0 || m_ack_o !== 2'b00 || m_err_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      fails++;
      $display("FAIL to_ignored: got to %b ack %b err %b cyc %b, wanted 0 00 00 0",
               timeout_o, m_ack_o, m_err_o, s_cyc_o);
    end
    tick();
    s_ack_i = 1'b0;
    drive_m(1'b0, 0, 0, 0, '0, '0);
    grant_sb.push_back(1);
    resp_sb.push_back('{1, RETURN_ACK, 1'b1, 32'h0BADF00D});
    wait_grant(ok);
    tests_run++;
    if (!ok || grant_o !== 2'b10) begin
      fails++;
      $display("FAIL to_next: got %b, wanted 10", grant_o);
    end
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0BADF00D;
    tick();
    s_ack_i = 1'b0;
    drive_m(1'b1, 0, 0, 0, '0, '0);
    tick();
  endtask

  task automatic test_ack_boundary();
    bit ok;
    int bad;
    tick();
    drive_m(1'b0, 1, 1, 1, 16'h0034, 32'h0000BEEF);
    grant_sb.push_back(0);
    resp_sb.push_back('{0, RETURN_ACK, 1'b0, 32'h0});
    wait_grant(ok);
    tests_run++;
    if (!ok || grant_o !== 2'b01 || s_stb_o !== 1'b1) begin
      fails++;
      $display("FAIL ab_strobe: got grant %b stb %b, wanted 01 1", grant_o, s_stb_o);
    end
    bad = 0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 1) drive_m(1'b0, 1, 0, 1, 16'h0034, 32'h0000BEEF);
      if (c == TO - 1) s_ack_i = 1'b1;
      if (c == TO) s_ack_i = 1'b0;
      @(negedge clk);
      if (timeout_o !== 1'b0 || m_err_o !== 2'b00) bad++;
      if (c == TO - 1) begin
        tests_run++;
        if (m_ack_o !== 2'b01) begin
          fails++;
          $display("FAIL ab_ack: got %b, wanted 01", m_ack_o);
        end
      end
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL ab_no_abort: got %0d error/timeout cycles, wanted 0", bad);
    end
    tests_run++;
    if (s_cyc_o !== 1'b1 || grant_o !== 2'b01) begin
      fails++;
      $display("FAIL ab_still_owned: got cyc %b grant %b, wanted 1 01", s_cyc_o, grant_o);
    end
    tick();
    drive_m(1'b0, 0, 0, 0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    tick();
    drive_m(1'b1, 1, 1, 0, 16'h0070, '0);
    grant_sb.push_back(1);
    wait_grant(ok);
    tests_run++;
    if (!ok || grant_o !== 2'b10) begin
      fails++;
      $display("FAIL rst_pre: got %b, wanted 10", grant_o);
    end
    tick();
    rst_i   = 1'b1;
    s_ack_i = 1'b1;
    s_dat_i = 32'h77777777;
    @(negedge clk);
    tests_run++;
    if (m_ack_o !== 2'b00 || m_err_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_abort: got ack %b err %b cyc %b, wanted 00 00 0", m_ack_o, m_err_o, s_cyc_o);
    end
    tick();
    rst_i   = 1'b0;
    s_ack_i = 1'b0;
    drive_m(1'b0, 1, 1, 0, 16'h0080, '0);
    grant_sb.push_back(0);
    resp_sb.push_back('{0, RETURN_ACK, 1'b1, 32'h600DCAFE});
    @(negedge clk);
    tests_run++;
    if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_post: got grant %b cyc %b, wanted 00 0", grant_o, s_cyc_o);
    end
    wait_grant(ok);
    tests_run++;
    if (!ok || grant_o !== 2'b01) begin
      fails++;
      $display("FAIL rst_first: got %b, wanted 01", grant_o);
    end
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h600DCAFE;
    tick();
    s_ack_i = 1'b0;
    drive_m(1'b0, 0, 0, 0, '0, '0);
    drive_m(1'b1, 0, 0, 0, '0, '0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, wanted finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_classic_read();
    test_fairness();
    test_rmw();
    test_timeout();
    test_ack_boundary();
    test_reset_mid();
    tests_run++;
    if (grant_sb.size() != 0) begin
      fails++;
      $display("FAIL grant_sb_empty: got %0d pending, wanted 0", grant_sb.size());
    end
    tests_run++;
    if (resp_sb.size() != 0) begin
      fails++;
      $display("FAIL resp_sb_empty: got %0d pending, wanted 0", resp_sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
